// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a multi-beat DPRO dot product.
// Define ALU_SAT_EN to saturate alu_out on overflow instead of wrapping.
module alu_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned OP_W    = 3,
   parameter int unsigned VEC_LEN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   op_code,
   input  logic [DATA_W-1:0] alu_in1,
   input  logic [DATA_W-1:0] alu_in2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_out,
   output logic              out_err,
   output logic              out_ovf
);

   localparam int unsigned CntW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int unsigned ProdW = 2 * DATA_W;
   localparam int unsigned ExtW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int unsigned AccW  = ProdW + ExtW;

   localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
   localparam logic [OP_W-1:0] OpMul  = OP_W'(1);
   localparam logic [OP_W-1:0] OpLdr  = OP_W'(4);
   localparam logic [OP_W-1:0] OpStr  = OP_W'(5);
   localparam logic [OP_W-1:0] OpMov  = OP_W'(6);
   localparam logic [OP_W-1:0] OpDpro = OP_W'(7);

   logic              ready_en_q;
   logic              s1_valid_q, s1_valid_d;
   logic [OP_W-1:0]   s1_op_q, s1_op_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic              s2_err_q, s2_err_d;
   logic              s2_ovf_q, s2_ovf_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [AccW-1:0]   acc_q, acc_d;

   logic              is_dpro, is_last, s2_adv, s1_adv, accept;
   logic [ProdW-1:0]  a_ext, b_ext, sum_ab, prod;
   logic [AccW-1:0]   sext_sum, sext_prod, sext_a, acc_sum, full;
   logic              err, emit, ovf;
   logic [DATA_W-1:0] res;
   logic [AccW-DATA_W:0] full_top;

   assign is_dpro = (s1_op_q == OpDpro);
   assign is_last = (cnt_q == CntW'(VEC_LEN - 1));
   assign s2_adv  = !s2_valid_q || out_ready;
   // A non-final DPRO beat only touches the accumulator, so it may leave S1 while S2 is stalled.
   assign s1_adv  = s1_valid_q && (s2_adv || (is_dpro && !is_last));
   assign in_ready = ready_en_q && (!s1_valid_q || s1_adv);
   assign accept  = in_valid && in_ready;

   // Low 2*DATA_W bits of sign-extended operands give the exact signed sum/product.
   assign a_ext     = {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q};
   assign b_ext     = {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q};
   assign sum_ab    = a_ext + b_ext;
   assign prod      = a_ext * b_ext;
   assign sext_sum  = {{ExtW{sum_ab[ProdW-1]}}, sum_ab};
   assign sext_prod = {{ExtW{prod[ProdW-1]}}, prod};
   assign sext_a    = {{(AccW-DATA_W){s1_a_q[DATA_W-1]}}, s1_a_q};
   assign acc_sum   = acc_q + sext_prod;

   always_comb begin
      full  = '0;
      err   = 1'b0;
      emit  = 1'b1;
      cnt_d = cnt_q;
      acc_d = acc_q;
      case (s1_op_q)
         OpAdd, OpLdr, OpStr: full = sext_sum;
         OpMul:               full = sext_prod;
         OpMov:               full = sext_a;
         OpDpro: begin
            full = acc_sum;
            emit = is_last;
         end
         default:             err  = 1'b1;
      endcase
      // Any other op arriving mid-vector aborts the partial dot product.
      if (!is_dpro && (cnt_q != '0)) begin
         err = 1'b1;
      end
      if (s1_adv) begin
         if (is_dpro && !is_last) begin
            cnt_d = cnt_q + CntW'(1);
            acc_d = acc_sum;
         end else begin
            cnt_d = '0;
            acc_d = '0;
         end
      end
   end

   always_comb begin
      full_top = full[AccW-1:DATA_W-1];
      ovf      = !((&full_top) || !(|full_top));
`ifdef ALU_SAT_EN
      if (ovf) begin
         res = full[AccW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
         res = full[DATA_W-1:0];
      end
`else
      res = full[DATA_W-1:0];
`endif
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = op_code;
         s1_a_d     = alu_in1;
         s1_b_d     = alu_in2;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_err_d   = s2_err_q;
      s2_ovf_d   = s2_ovf_q;
      if (s2_adv) begin
         if (s1_adv && emit) begin
            s2_valid_d = 1'b1;
            s2_data_d  = res;
            s2_err_d   = err;
            s2_ovf_d   = ovf;
         end else begin
            s2_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_err_q   <= 1'b0;
         s2_ovf_q   <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
      end else begin
         ready_en_q <= 1'b1;
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_err_q   <= s2_err_d;
         s2_ovf_q   <= s2_ovf_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign alu_out   = s2_data_q;
   assign out_err   = s2_err_q;
   assign out_ovf   = s2_ovf_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, parametrised successor of the single-cycle ALU. It wraps the same opcode set behind valid/ready handshakes on both sides and registers every result. DPRO becomes a true multi-beat dot product: it accumulates VEC_LEN consecutive products and emits one sum. It sits between the operand fetch stage and writeback in the pixel datapath.

## Interface
- DATA_W, 32: operand and result width (signed two's complement)
- OP_W, 3: opcode width; codes ADD=000, MUL=001, LDR=100, STR=101, MOV=110, DPRO=111
- VEC_LEN, 4: beats per dot product; 2..256
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- op_code  input  OP_W  operation for this beat
- alu_in1  input  DATA_W  signed operand A
- alu_in2  input  DATA_W  signed operand B
- out_valid  output  1  result held valid until taken
- out_ready  input  1  result taken when out_valid && out_ready
- alu_out  output  DATA_W  result
- out_err  output  1  illegal opcode, or DPRO vector aborted, for this result
- out_ovf  output  1  full-precision result did not fit DATA_W signed

## Operation
- Two register stages: S1 captures op/operands; S2 holds the result, err and ovf.
- ADD, LDR, STR: A+B. MUL: A*B. MOV: A. Full precision is 2*DATA_W; alu_out takes the low DATA_W bits.
- Illegal opcodes (010, 011): alu_out=0, out_err=1, out_ovf=0.
- DPRO: the products of accepted DPRO beats are summed in an accumulator of 2*DATA_W+clog2(VEC_LEN) bits, with beat counter cnt running 0..VEC_LEN-1.
  - Beats with cnt<VEC_LEN-1 produce no output; cnt increments.
  - The beat at cnt=VEC_LEN-1 writes the final sum to S2; cnt and acc clear.
- Non-DPRO beat accepted while cnt!=0: the partial sum is discarded and cnt/acc clear. That beat's own result is issued with out_err=1.
- out_ovf=1 when the full-precision value is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]. This covers the sum, product or dot result.
- Accumulator state: IDLE (cnt=0) and ACC (cnt>0).
  - IDLE->ACC on a DPRO beat when VEC_LEN>1.
  - ACC->IDLE on the last DPRO beat or on an abort.

## Timing
- Reset: in_ready=0 while rst_n low, 1 from the first clk after release. out_valid=0, alu_out=0, out_err=0, out_ovf=0, cnt=0, acc=0, both stages empty.
- Latency: a beat accepted at edge N gives out_valid at edge N+2, provided S2 is free. For DPRO, N is the last beat.
- Throughput: one beat/cycle with out_ready held 1.
- Backpressure:
  - S2 advances when it is empty or out_ready=1.
  - S1 advances when S2 advances, or when S1 holds a non-final DPRO beat, which needs no S2 slot.
  - in_ready = S1 empty or S1 advancing. This is a combinational path from out_ready.
- alu_out, out_err and out_ovf stay stable while out_valid && !out_ready.
- Simultaneous final DPRO beat and out_ready: the old result leaves and the new sum loads on the same edge. There is no bubble.
- Reset mid-vector: the partial accumulation is lost; there is no output for it.

## Configuration
- ALU_SAT_EN defined: when out_ovf=1, alu_out saturates to 2^(DATA_W-1)-1 or -2^(DATA_W-1) according to the sign of the full-precision value.
- ALU_SAT_EN undefined: alu_out wraps (low DATA_W bits). out_ovf behaves identically in both builds.

## Test plan
- DATA_W=32. ADD 5+(-7), then MUL -3*4, with out_ready=1 -> results -2, then -12, at edges N+2 and N+3; err=0, ovf=0.
- MUL 0x40000000*4 -> out_ovf=1. alu_out=0x00000000 without ALU_SAT_EN; 0x7FFFFFFF with it.
- VEC_LEN=4, DPRO pairs (1,2)(3,4)(-5,6)(7,8) -> exactly one output, 2+12-30+56=40, two edges after the 4th beat.
- DPRO (1,1)(2,2), then ADD 1+1 -> single output 2 with out_err=1. A following full DPRO vector (1,1)x4 -> 4. This proves the clear.
- out_ready=0 for 5 cycles during a stream of 6 ADDs -> in_ready drops after 2 beats held in S1/S2. No result is lost, duplicated or reordered, and alu_out is stable while stalled.
- Assert rst_n low after 2 DPRO beats, release, send op 010 -> alu_out=0 with out_err=1; then 4 DPRO (2,3) -> 24.
